// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED pattern controller
// Shared tick prescaler; per channel OFF/ON/BLINK/BURST with a one-cycle DONE pulse at burst end.
module led_pattern_ctrl #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 3,
  parameter int PER_W   = 12,
  parameter int CNT_W   = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [1:0]       CFG_MODE,
  input  logic [PER_W-1:0] CFG_PERIOD,
  input  logic [PER_W-1:0] CFG_ON,
  input  logic [CNT_W-1:0] CFG_COUNT,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  DONE,
  output logic             TICK
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PC_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || N_CH < 1 || N_CH > 8) begin : g_bad_params
      $error("led_pattern_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2 and N_CH in 1..8");
    end
  endgenerate

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ready_q, ready_d;
  logic             tick;
  logic             wr_en;

  logic [1:0]       mode_q   [N_CH];
  logic [1:0]       mode_d   [N_CH];
  logic [PER_W-1:0] period_q [N_CH];
  logic [PER_W-1:0] period_d [N_CH];
  logic [PER_W-1:0] on_q     [N_CH];
  logic [PER_W-1:0] on_d     [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
  logic [PER_W-1:0] ph_q     [N_CH];
  logic [PER_W-1:0] ph_d     [N_CH];
  logic [CNT_W-1:0] bc_q     [N_CH];
  logic [CNT_W-1:0] bc_d     [N_CH];
  logic [N_CH-1:0]  led_q, led_d;
  logic [N_CH-1:0]  done_q, done_d;

  assign tick      = (pc_q == PC_W'(DIV - 1));
  assign wr_en     = CFG_VALID && ready_q;
  assign TICK      = tick;
  assign CFG_READY = ready_q;
  assign LED       = led_q;
  assign DONE      = done_q;

  always_comb begin
    pc_d    = tick ? '0 : pc_q + 1'b1;
    ready_d = 1'b1;
    led_d   = '0;
    done_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      on_d[i]     = on_q[i];
      count_d[i]  = count_q[i];
      ph_d[i]     = ph_q[i];
      bc_d[i]     = bc_q[i];
      if (wr_en && CFG_CH == CH_W'(i)) begin
        // A write restarts the channel and masks any tick in the same cycle.
        mode_d[i]   = CFG_MODE;
        period_d[i] = CFG_PERIOD;
        on_d[i]     = CFG_ON;
        count_d[i]  = CFG_COUNT;
        ph_d[i]     = '0;
        bc_d[i]     = '0;
        if (CFG_MODE == MODE_BLINK && CFG_PERIOD == '0) begin
          mode_d[i] = MODE_OFF;
        end
        if (CFG_MODE == MODE_BURST && (CFG_PERIOD == '0 || CFG_COUNT == '0)) begin
          mode_d[i] = MODE_OFF;
          done_d[i] = 1'b1;
        end
      end else if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
        if (ph_q[i] == period_q[i] - 1'b1) begin
          ph_d[i] = '0;
          if (mode_q[i] == MODE_BURST) begin
            if (bc_q[i] == count_q[i] - 1'b1) begin
              mode_d[i] = MODE_OFF;
              done_d[i] = 1'b1;
            end else begin
              bc_d[i] = bc_q[i] + 1'b1;
            end
          end
        end else begin
          ph_d[i] = ph_q[i] + 1'b1;
        end
      end
      case (mode_d[i])
        MODE_ON:                led_d[i] = 1'b1;
        MODE_BLINK, MODE_BURST: led_d[i] = (ph_d[i] < on_d[i]);
        default:                led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q    <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      done_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        on_q[i]     <= '0;
        count_q[i]  <= '0;
        ph_q[i]     <= '0;
        bc_q[i]     <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      ready_q <= ready_d;
      led_q   <= led_d;
      done_q  <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        on_q[i]     <= on_d[i];
        count_q[i]  <= count_d[i];
        ph_q[i]     <= ph_d[i];
        bc_q[i]     <= bc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed self-checking bench for led_pattern_ctrl
// DIV=10, three channels; inputs change and outputs are sampled on the falling edge.
module tb_led_pattern_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [11:0] cfg_period;
  logic [11:0] cfg_on;
  logic [7:0]  cfg_count;
  logic [2:0]  led;
  logic [2:0]  done;
  logic        tick;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  bit tick_edge = 1'b0;
  int k;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_CH(3), .PER_W(12), .CNT_W(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready), .CFG_CH(cfg_ch),
    .CFG_MODE(cfg_mode), .CFG_PERIOD(cfg_period), .CFG_ON(cfg_on), .CFG_COUNT(cfg_count),
    .LED(led), .DONE(done), .TICK(tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the bench prescaler model and check TICK against it.
  task automatic step();
    bit in_rst;
    int old;
    in_rst = !rst_n;
    old    = exp_pc;
    @(negedge clk);
    tick_edge = !in_rst && (old == 9);
    exp_pc    = in_rst ? 0 : ((old == 9) ? 0 : old + 1);
    chk("tick", tick, (exp_pc == 9));
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [11:0] per,
                    input logic [11:0] on_t, input logic [7:0] cnt);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_on     = on_t;
    cfg_count  = cnt;
    chk("cfg_ready", cfg_ready, 1);
    step();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_on = '0; cfg_count = '0;

    for (int s = 0; s < 5; s++) begin
      step();
      chk("rst_led", led, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cfg_ready, 0);
    end
    rst_n = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 1) chk("ready_after_release", cfg_ready, 1);
    end
    chk("first_tick", tick, 1);
    for (int s = 0; s < 10; s++) step();
    chk("second_tick", tick, 1);
    step();

    // BLINK ch0: period 4, on 1
    wr(2'd0, 2'd2, 12'd4, 12'd1, 8'd0);
    chk("blink_first", led, 3'b001);
    k = 0;
    for (int s = 0; s < 50; s++) begin
      step();
      if (tick_edge) k++;
      chk("blink_led", led, {2'b00, (k % 4) == 0});
    end

    // BURST ch1: period 2, on 1, count 3
    if (exp_pc == 9) step();
    wr(2'd1, 2'd3, 12'd2, 12'd1, 8'd3);
    chk("burst_first", led[1], 1);
    k = 0;
    for (int s = 0; s < 70; s++) begin
      step();
      if (tick_edge) k++;
      chk("burst_led", led[1], (k < 6) ? ((k % 2) == 0) : 0);
      chk("burst_done", done, (k == 6 && tick_edge) ? 3'b010 : 3'b000);
    end

    // Edge configurations on ch2
    wr(2'd2, 2'd3, 12'd4, 12'd1, 8'd0);
    chk("count0_done", done, 3'b100);
    chk("count0_led", led[2], 0);
    step();
    chk("count0_done_clear", done, 0);
    wr(2'd2, 2'd3, 12'd0, 12'd1, 8'd2);
    chk("burst_per0_done", done, 3'b100);
    chk("burst_per0_led", led[2], 0);
    wr(2'd2, 2'd2, 12'd0, 12'd1, 8'd0);
    chk("blink_per0_done", done, 0);
    for (int s = 0; s < 15; s++) begin
      step();
      chk("blink_per0_led", led[2], 0);
    end
    wr(2'd2, 2'd2, 12'd4, 12'd5, 8'd0);
    for (int s = 0; s < 45; s++) begin
      step();
      chk("on_ge_period_led", led[2], 1);
    end
    wr(2'd0, 2'd1, 12'd0, 12'd0, 8'd0);
    chk("ch0_on", led, 3'b101);
    wr(2'd3, 2'd0, 12'd0, 12'd0, 8'd0);
    for (int s = 0; s < 20; s++) begin
      step();
      chk("ch3_no_effect", led, 3'b101);
      chk("ch3_no_done", done, 0);
    end

    // Write ch2 coincident with a TICK
    for (int s = 0; s < 10 && exp_pc != 9; s++) step();
    wr(2'd2, 2'd2, 12'd4, 12'd1, 8'd0);
    chk("simul_led0", led[2], 1);
    for (int s = 1; s <= 9; s++) begin
      step();
      chk("simul_hold", led[2], 1);
    end
    step();
    chk("simul_advance", led[2], 0);

    // Reset during the second burst period
    if (exp_pc == 9) step();
    wr(2'd1, 2'd3, 12'd2, 12'd1, 8'd3);
    k = 0;
    for (int s = 0; s < 30 && k < 2; s++) begin
      step();
      if (tick_edge) k++;
    end
    step();
    step();
    rst_n = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("midrst_led", led, 0);
      chk("midrst_done", done, 0);
      chk("midrst_ready", cfg_ready, 0);
    end
    rst_n = 1'b1;
    step();
    chk("midrst_ready_back", cfg_ready, 1);
    for (int s = 0; s < 40; s++) begin
      step();
      chk("post_rst_led", led, 0);
      chk("post_rst_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
